seq_booth_multiplier: RTL and testbench



---
 rtl/seq_booth_multiplier.sv | 128 ++++++++++++
 tb/tb_seq_booth_multiplier.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seq_booth_multiplier.sv
// Multi-cycle radix-2 Booth multiplier, signed/unsigned selectable at start.
// Optional early termination when SEQ_MULT_EARLY_TERM_EN is defined.
module seq_booth_multiplier #(
  parameter int unsigned WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d, q_q, q_d, x_q, x_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic               done_q, done_d, busy_q, busy_d;

  logic [WIDTH:0]     a_s, a_sh, q_sh, a_n, q_n;
  logic               last;

`ifdef SEQ_MULT_EARLY_TERM_EN
  logic [WIDTH:0]          mask;
  logic [CW-1:0]           rem;
  logic signed [2*WIDTH+1:0] prod;
`endif

  always_comb begin
    unique case ({q_q[0], qm1_q})
      2'b10:   a_s = a_q - x_q;
      2'b01:   a_s = a_q + x_q;
      default: a_s = a_q;
    endcase
    a_sh = {a_s[WIDTH], a_s[WIDTH:1]};
    q_sh = {a_s[0], q_q[WIDTH:1]};
    a_n  = a_sh;
    q_n  = q_sh;
`ifdef SEQ_MULT_EARLY_TERM_EN
    // q_q[WIDTH-k:0] still holds the unprocessed multiplier bits k..WIDTH;
    // once they are uniform every later step is a pure shift.
    mask = {(WIDTH+1){1'b1}} >> cnt_q;
    rem  = CW'(WIDTH) - cnt_q;
    prod = {a_sh, q_sh};
    last = ((q_q & mask) == '0) || ((q_q & mask) == mask);
    if (last) begin
      {a_n, q_n} = prod >>> rem;
    end
`else
    last = (cnt_q == CW'(WIDTH));
`endif
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    x_d     = x_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: state_d = IDLE;
      CALC: begin
        a_d   = a_n;
        q_d   = q_n;
        qm1_d = q_q[0];
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          done_d  = 1'b1;
          out_d   = {a_n[WIDTH-2:0], q_n};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A start seen on the DONE->IDLE edge is accepted so results can be
    // issued every WIDTH+2 cycles.
    if ((state_q == IDLE || state_q == DONE) && start) begin
      state_d = CALC;
      a_d     = '0;
      q_d     = {sgn & y[WIDTH-1], y};
      x_d     = {sgn & x[WIDTH-1], x};
      qm1_d   = 1'b0;
      cnt_d   = '0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      x_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      x_q     <= x_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign out  = out_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed self-checking bench for seq_booth_multiplier (WIDTH=5).
module tb_seq_booth_multiplier;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sgn = 1'b0;
  logic [4:0] x = '0;
  logic [4:0] y = '0;
  logic       busy, done;
  logic [9:0] out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_booth_multiplier #(.WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sgn   (sgn),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected start-to-done latency; early termination ends after the first
  // step k whose remaining extended multiplier bits k..5 are uniform.
  function automatic int exp_lat(input logic s, input logic [4:0] yv);
    logic [5:0] ye;
    int lat_et;
    ye = {s & yv[4], yv};
    lat_et = 6;
    for (int k = 5; k >= 0; k--) begin
      logic eq;
      eq = 1'b1;
      for (int j = k; j <= 5; j++) if (ye[j] != ye[5]) eq = 1'b0;
      if (eq) lat_et = k + 1;
    end
`ifdef SEQ_MULT_EARLY_TERM_EN
    return lat_et;
`else
    return (lat_et > 0) ? 6 : 6;
`endif
  endfunction

  task automatic mul_op(input string tag, input logic s, input logic [4:0] xv,
                        input logic [4:0] yv, input logic [9:0] expv);
    int lat;
    @(negedge clk);
    sgn = s; x = xv; y = yv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = ~xv; y = ~yv; sgn = ~s;
    check({tag, "_busy_rise"}, busy, 1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    check({tag, "_lat"}, lat, exp_lat(s, yv));
    check({tag, "_out"}, out, expv);
    @(posedge clk); #1;
    check({tag, "_done_fall"}, done, 0);
    check({tag, "_busy_fall"}, busy, 0);
    repeat (2) @(posedge clk);
    #1 check({tag, "_out_hold"}, out, expv);
  endtask

  initial begin
    int d1, d2, e1, e2, ndone;

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out", out, 0);
    @(negedge clk) rst_n = 1'b1;

    mul_op("s_2x4",    1'b1, 5'd2,  5'd4,  10'd8);
    mul_op("s_m5xm3",  1'b1, 5'd27, 5'd29, 10'd15);
    mul_op("s_m16sq",  1'b1, 5'd16, 5'd16, 10'd256);
    mul_op("u_31sq",   1'b0, 5'd31, 5'd31, 10'd961);
    mul_op("s_m1x1",   1'b1, 5'd31, 5'd1,  10'h3FF);
    mul_op("u_y0",     1'b0, 5'd13, 5'd0,  10'd0);
    mul_op("u_11x1",   1'b0, 5'd11, 5'd1,  10'd11);

    // start held high through CALC and onto the DONE->IDLE edge
    d1 = exp_lat(1'b0, 5'd9);
    d2 = d1 + 1 + exp_lat(1'b0, 5'd6);
    e1 = -1; e2 = -1; ndone = 0;
    @(negedge clk);
    sgn = 1'b0; x = 5'd7; y = 5'd9; start = 1'b1;
    for (int e = 0; e <= 20; e++) begin
      @(posedge clk); #1;
      if (e == 0) begin x = 5'd20; y = 5'd6; end
      if (e == d1 + 1) start = 1'b0;
      if (done) begin
        ndone++;
        if (e1 < 0) begin e1 = e; check("b2b_out1", out, 63); end
        else begin e2 = e; check("b2b_out2", out, 120); end
      end
      if (e == d1 + 3) check("b2b_hold", out, 63);
    end
    check("b2b_ndone", ndone, 2);
    check("b2b_edge1", e1, d1);
    check("b2b_edge2", e2, d2);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    sgn = 1'b0; x = 5'd9; y = 5'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_out", out, 0);
    @(negedge clk) rst_n = 1'b1;
    mul_op("post_rst", 1'b0, 5'd11, 5'd1, 10'd11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
